// File: rtl/fan_ctrl_multi.sv
// Multi-channel PWM fan controller: shared prescaler/PWM counter, per-channel duty
// ramping toward a target, and tach-based stall detection that forces full duty.
module fan_ctrl_multi #(
    parameter int NumCh        = 2,
    parameter int PwmWidth     = 4,
    parameter int PrescaleDiv  = 16,
    parameter int RampEn       = 1,
    parameter int StallPeriods = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumCh-1:0]          en_i,
    input  logic [NumCh*PwmWidth-1:0] setting_i,
    input  logic [NumCh-1:0]          tach_i,
    output logic [NumCh-1:0]          pwm_o,
    output logic [NumCh*PwmWidth-1:0] duty_o,
    output logic [NumCh-1:0]          stall_o,
    output logic                      period_tick_o
);

    localparam int PsW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [PsW-1:0]      PsLast  = PsW'(PrescaleDiv - 1);
    localparam logic [PwmWidth-1:0] DutyMax = {PwmWidth{1'b1}};
    localparam logic [PwmWidth-1:0] DutyOne = PwmWidth'(1);

    logic [PsW-1:0]      presc;
    logic [PwmWidth-1:0] cnt;
    logic                step;
    logic                pe;

    assign step = (presc == PsLast);
    assign pe   = step && (cnt == DutyMax);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc         <= '0;
            cnt           <= '0;
            period_tick_o <= 1'b0;
        end else begin
            presc         <= step ? '0 : presc + PsW'(1);
            if (step) begin
                cnt <= cnt + DutyOne;
            end
            period_tick_o <= pe;
        end
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        logic [PwmWidth-1:0] setting;
        logic [PwmWidth-1:0] tgt;
        logic [PwmWidth-1:0] duty;
        logic [PwmWidth-1:0] duty_next;
        logic                pwm;
        logic                stall;

        assign setting = setting_i[c*PwmWidth +: PwmWidth];
        assign tgt     = !en_i[c] ? '0 : (stall ? DutyMax : setting);

        // Ramping never overshoots: one step per period, only while unequal.
        always_comb begin
            duty_next = duty;
            if (RampEn == 0) begin
                duty_next = tgt;
            end else if (duty < tgt) begin
                duty_next = duty + DutyOne;
            end else if (duty > tgt) begin
                duty_next = duty - DutyOne;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                duty <= '0;
                pwm  <= 1'b0;
            end else begin
                if (pe) begin
                    duty <= duty_next;
                end
                pwm <= en_i[c] && ((cnt < duty) || (duty == DutyMax));
            end
        end

        if (StallPeriods > 0) begin : g_stall
            localparam int ScW = $clog2(StallPeriods + 1);
            localparam logic [ScW-1:0] SatVal = ScW'(StallPeriods);

            logic [2:0]     sync;
            logic           rise;
            logic [ScW-1:0] scnt;
            logic           stall_q;

            assign rise = sync[1] && !sync[2];

            // A disabled or stopped fan is never counted toward a stall.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync    <= '0;
                    scnt    <= '0;
                    stall_q <= 1'b0;
                end else begin
                    sync <= {sync[1:0], tach_i[c]};
                    if (!en_i[c] || (duty == '0) || rise) begin
                        scnt <= '0;
                    end else if (pe && (scnt != SatVal)) begin
                        scnt <= scnt + ScW'(1);
                    end
                    if (!en_i[c] || rise) begin
                        stall_q <= 1'b0;
                    end else if ((scnt == SatVal) && (duty != '0)) begin
                        stall_q <= 1'b1;
                    end
                end
            end

            assign stall = stall_q;
        end else begin : g_nostall
            logic unused_tach;
            assign unused_tach = tach_i[c];
            assign stall       = 1'b0;
        end

        assign pwm_o[c]                        = pwm;
        assign duty_o[c*PwmWidth +: PwmWidth] = duty;
        assign stall_o[c]                      = stall;
    end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Scoreboard bench for fan_ctrl_multi: a ramping/stall-detecting instance and a
// jump-to-target instance without stall detection share the same stimulus.
module tb_fan_ctrl_multi;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] en_i;
    logic [7:0] setting_i;
    logic [1:0] tach_i;

    logic [1:0] pwm_a, stall_a, pwm_b, stall_b;
    logic [7:0] duty_a, duty_b;
    logic       tick_a, tick_b;

    always #5 clk_i = ~clk_i;

    fan_ctrl_multi #(
        .NumCh(2), .PwmWidth(4), .PrescaleDiv(2), .RampEn(1), .StallPeriods(4)
    ) u_ramp (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .setting_i(setting_i),
        .tach_i(tach_i), .pwm_o(pwm_a), .duty_o(duty_a), .stall_o(stall_a),
        .period_tick_o(tick_a)
    );

    fan_ctrl_multi #(
        .NumCh(2), .PwmWidth(4), .PrescaleDiv(2), .RampEn(0), .StallPeriods(0)
    ) u_jump (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .setting_i(setting_i),
        .tach_i(tach_i), .pwm_o(pwm_b), .duty_o(duty_b), .stall_o(stall_b),
        .period_tick_o(tick_b)
    );

    typedef struct {
        int ad0, ad1, ast, bd0, bd1;
        int ap0, ap1, bp0, bp1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   prev_a0, prev_a1, prev_b0, prev_b1;
    int   cyc, apc0, apc1, bpc0, bpc1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // High cycles over one 32-cycle period for a given duty.
    function automatic int pwm_exp(input int en, input int d);
        if (en == 0) return 0;
        if (d == 15) return 32;
        return 2 * d;
    endfunction

    // Tach modes: 0 hold low, 1 mid-period pulse, 2 rising edge coincident with period end.
    task automatic run_period(input int en, input int s0, input int s1, input int m0, input int m1,
                              input int ead0, input int ead1, input int east,
                              input int ebd0, input int ebd1);
        exp_t e;
        int   m;
        en_i      = 2'(en);
        setting_i = {4'(s1), 4'(s0)};
        e.ad0 = ead0; e.ad1 = ead1; e.ast = east; e.bd0 = ebd0; e.bd1 = ebd1;
        e.ap0 = pwm_exp(en & 1, prev_a0);
        e.ap1 = pwm_exp((en >> 1) & 1, prev_a1);
        e.bp0 = pwm_exp(en & 1, prev_b0);
        e.bp1 = pwm_exp((en >> 1) & 1, prev_b1);
        prev_a0 = ead0; prev_a1 = ead1; prev_b0 = ebd0; prev_b1 = ebd1;
        q.push_back(e);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk_i);
            for (int c = 0; c < 2; c++) begin
                m = (c == 0) ? m0 : m1;
                if (m == 1 && i == 8)  tach_i[c] = 1'b1;
                if (m == 1 && i == 12) begin
                    tach_i[c] = 1'b0;
                    check($sformatf("stall_clear_after_tach%0d", c), 32'(stall_a[c]), 0);
                end
                if (m == 2 && i == 29) tach_i[c] = 1'b1;
                if (m == 2 && i == 31) tach_i[c] = 1'b0;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            cyc = 0; apc0 = 0; apc1 = 0; bpc0 = 0; bpc1 = 0;
        end else begin
            cyc++;
            apc0 += int'(pwm_a[0]); apc1 += int'(pwm_a[1]);
            bpc0 += int'(pwm_b[0]); bpc1 += int'(pwm_b[1]);
            if (tick_a) begin
                check("tick_gap", cyc, 32);
                check("tick_b", 32'(tick_b), 1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: actual=tick required=no_tick at %0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    check("a_duty0", 32'(duty_a[3:0]), mon_e.ad0);
                    check("a_duty1", 32'(duty_a[7:4]), mon_e.ad1);
                    check("a_stall", 32'(stall_a), mon_e.ast);
                    check("a_pwm0_high", apc0, mon_e.ap0);
                    check("a_pwm1_high", apc1, mon_e.ap1);
                    check("b_duty0", 32'(duty_b[3:0]), mon_e.bd0);
                    check("b_duty1", 32'(duty_b[7:4]), mon_e.bd1);
                    check("b_pwm0_high", bpc0, mon_e.bp0);
                    check("b_pwm1_high", bpc1, mon_e.bp1);
                    check("b_stall", 32'(stall_b), 0);
                end
                cyc = 0; apc0 = 0; apc1 = 0; bpc0 = 0; bpc1 = 0;
            end
        end
    end

    initial begin
        rst_i = 1'b1; en_i = '0; setting_i = '0; tach_i = '0;
        prev_a0 = 0; prev_a1 = 0; prev_b0 = 0; prev_b1 = 0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;

        // Ramp up from 0 with regular tach pulses.
        run_period(3, 8, 4, 1, 1, 1, 1, 0, 8, 4);
        for (int k = 2; k <= 4; k++) run_period(3, 8, 4, 1, 1, k, k, 0, 8, 4);
        run_period(3, 8, 4, 1, 1, 5, 4, 0, 8, 4);
        run_period(3, 8, 2, 1, 1, 6, 3, 0, 8, 2);
        run_period(3, 8, 2, 1, 1, 7, 2, 0, 8, 2);
        run_period(3, 8, 2, 1, 1, 8, 2, 0, 8, 2);
        run_period(3, 8, 2, 1, 1, 8, 2, 0, 8, 2);

        // Ch0: tach edge lands on the period end, then tach held low -> stall.
        run_period(3, 8, 2, 2, 1, 8, 2, 0, 8, 2);
        for (int k = 0; k < 4; k++) run_period(3, 8, 2, 0, 1, 8, 2, 0, 8, 2);
        for (int k = 9; k <= 15; k++) run_period(3, 8, 2, 0, 1, k, 2, 1, 8, 2);
        run_period(3, 8, 2, 0, 1, 15, 2, 1, 8, 2);

        // One tach pulse clears ch0 stall; ch1 tach now held low.
        run_period(3, 8, 2, 1, 1, 14, 2, 0, 8, 2);
        for (int k = 0; k < 3; k++) run_period(3, 8, 2, 1, 0, 13 - k, 2, 0, 8, 2);
        for (int k = 0; k < 3; k++) run_period(3, 8, 2, 1, 0, 10 - k, 3 + k, 2, 8, 2);

        // Ch0 disabled with tach low: no stall, duty ramps to 0; ch1 keeps ramping.
        for (int k = 0; k < 8; k++) run_period(2, 8, 2, 0, 0, 7 - k, 6 + k, 2, 0, 2);

        // Asynchronous reset mid-period while ch1 drives high.
        for (int i = 1; i <= 4; i++) @(negedge clk_i);
        check("pre_reset_pwm1", 32'(pwm_a[1]), 1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_pwm_a", 32'(pwm_a), 0);
        check("rst_duty_a", 32'(duty_a), 0);
        check("rst_stall_a", 32'(stall_a), 0);
        check("rst_tick_a", 32'(tick_a), 0);
        check("rst_pwm_b", 32'(pwm_b), 0);
        check("rst_duty_b", 32'(duty_b), 0);
        tach_i = '0;
        prev_a0 = 0; prev_a1 = 0; prev_b0 = 0; prev_b1 = 0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;

        run_period(3, 8, 4, 1, 1, 1, 1, 0, 8, 4);
        run_period(3, 8, 4, 1, 1, 2, 2, 0, 8, 4);

        @(negedge clk_i);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
